interrupt_controller: RTL and testbench

Parametrised interrupt flag/enable block that generalises the fixed five-source IF/IE logic into a NUM_INT-channel controller. It adds rising-edge source capture, fixed-priority arbitration, a frozen vector and a registered request/acknowledge handshake towards the CPU. It sits on the 0xFFxx special-register bus beside the joypad, LCD and DMA registers, and drives the CPU interrupt dispatch.

---
 rtl/interrupt_controller_pkg.sv | 28 ++
 rtl/interrupt_controller_priority_encoder.sv | 27 ++
 rtl/interrupt_controller.sv | 128 ++++++++++++
 tb/tb_interrupt_controller.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt flag/enable controller: channel numbers,
// default register addresses, vector layout and the request state encoding.
package gb_int_pkg;

    localparam int unsigned INT_VBLANK = 0;
    localparam int unsigned INT_STAT   = 1;
    localparam int unsigned INT_TIMER  = 2;
    localparam int unsigned INT_SERIAL = 3;
    localparam int unsigned INT_JOYPAD = 4;

    localparam logic [15:0] ADDR_IF_DEFAULT       = 16'hFF0F;
    localparam logic [15:0] ADDR_IE_DEFAULT       = 16'hFFFF;
    localparam logic [15:0] VECTOR_BASE_DEFAULT   = 16'h0040;
    localparam int unsigned VECTOR_STRIDE_DEFAULT = 8;

    typedef enum logic {
        ST_IDLE,
        ST_REQUEST
    } int_state_t;

    // Vector address arithmetic wraps at 16 bits.
    function automatic logic [15:0] vector_addr(input logic [15:0] base,
                                                input int unsigned stride,
                                                input logic [2:0]  idx);
        return 16'(32'(base) + stride * 32'(idx));
    endfunction

endpackage

// File: rtl/interrupt_controller_priority_encoder.sv
// Fixed-priority encoder: reports the lowest set bit among the first NUM_INT
// masked flags.
module int_priority_encoder #(
    parameter int unsigned NUM_INT = 5
) (
    input  logic [7:0] flags,
    output logic [2:0] index,
    output logic       valid
);

    // Bits at or above NUM_INT are never candidates; folded here only so the
    // full bus width is consumed.
    logic unused_flags;
    assign unused_flags = ^flags;

    always_comb begin
        index = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < NUM_INT; i++) begin
            if (!valid && flags[i]) begin
                valid = 1'b1;
                index = 3'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// NUM_INT-channel interrupt controller: edge-captured IF flags, IE enables,
// fixed-priority arbitration and a registered request/acknowledge to the CPU.
module interrupt_controller #(
    parameter int unsigned NUM_INT       = 5,
    parameter logic [15:0] ADDR_IF       = gb_int_pkg::ADDR_IF_DEFAULT,
    parameter logic [15:0] ADDR_IE       = gb_int_pkg::ADDR_IE_DEFAULT,
    parameter logic [15:0] VECTOR_BASE   = gb_int_pkg::VECTOR_BASE_DEFAULT,
    parameter int unsigned VECTOR_STRIDE = gb_int_pkg::VECTOR_STRIDE_DEFAULT
) (
    input  logic               clk4_2,
    input  logic               reset_n,
    input  logic               write,
    input  logic [15:0]        address_bus_offset,
    input  logic [7:0]         data_in,
    input  logic [NUM_INT-1:0] int_sig,
    input  logic               IME,
    input  logic               int_ack,
    output logic [7:0]         IF,
    output logic [7:0]         IE,
    output logic               int_pending,
    output logic               int_req,
    output logic [15:0]        int_vector,
    output logic [2:0]         int_index
);

    import gb_int_pkg::*;

    int_state_t         state;
    logic [NUM_INT-1:0] sig_d;
    logic [NUM_INT-1:0] edge_det;
    logic [NUM_INT-1:0] if_flags;
    logic [NUM_INT-1:0] if_next;
    logic [7:0]         ie_reg;
    logic [7:0]         if_ext;
    logic [7:0]         masked;
    logic [2:0]         cand;
    logic               cand_valid;
    logic               wr_if;
    logic               wr_ie;
    logic               cur_flag;
    logic               cur_en;

    assign wr_if    = write && (address_bus_offset == ADDR_IF);
    assign wr_ie    = write && (address_bus_offset == ADDR_IE);
    assign edge_det = int_sig & ~sig_d;

    always_comb begin
        if_ext                = '0;
        if_ext[NUM_INT-1:0]   = if_flags;
        IF                    = '1;
        IF[NUM_INT-1:0]       = if_flags;
    end

    assign IE          = ie_reg;
    assign masked      = if_ext & ie_reg;
    assign int_pending = |masked;
    assign cur_flag    = if_ext[int_index];
    assign cur_en      = ie_reg[int_index];

    int_priority_encoder #(
        .NUM_INT (NUM_INT)
    ) u_prio (
        .flags (masked),
        .index (cand),
        .valid (cand_valid)
    );

    // Bus load, then ack clear, then hardware edge: later steps override.
    always_comb begin
        if_next = if_flags;
        if (wr_if) begin
            if_next = data_in[NUM_INT-1:0];
        end
        for (int unsigned i = 0; i < NUM_INT; i++) begin
            if (state == ST_REQUEST && int_ack && 3'(i) == int_index) begin
                if_next[i] = 1'b0;
            end
        end
        if_next = if_next | edge_det;
    end

    always_ff @(posedge clk4_2 or negedge reset_n) begin
        if (!reset_n) begin
            sig_d    <= '0;
            if_flags <= '0;
            ie_reg   <= '0;
        end else begin
            sig_d    <= int_sig;
            if_flags <= if_next;
            if (wr_ie) begin
                ie_reg <= data_in;
            end
        end
    end

    // Cancel is judged on the registered IF/IE/IME, so a bus clear of the
    // serviced flag drops the request one edge after the write lands.
    always_ff @(posedge clk4_2 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            int_req    <= 1'b0;
            int_vector <= '0;
            int_index  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (IME && cand_valid) begin
                        state      <= ST_REQUEST;
                        int_req    <= 1'b1;
                        int_index  <= cand;
                        int_vector <= vector_addr(VECTOR_BASE, VECTOR_STRIDE, cand);
                    end
                end
                ST_REQUEST: begin
                    if (int_ack || !IME || !cur_flag || !cur_en) begin
                        state   <= ST_IDLE;
                        int_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    int_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Randomised and directed bench for interrupt_controller, checked every cycle
// against a flag/enable/busy model plus literal expectations.
module tb_interrupt_controller;

    localparam int N = 5;

    logic        clk4_2 = 1'b0;
    logic        reset_n;
    logic        write;
    logic [15:0] addr;
    logic [7:0]  data_in;
    logic [4:0]  int_sig;
    logic        ime;
    logic        int_ack;
    logic [7:0]  if_o, ie_o;
    logic        pend, req;
    logic [15:0] vec;
    logic [2:0]  idx;

    logic        write_b;
    logic [15:0] addr_b;
    logic [7:0]  data_b;
    logic [7:0]  sig_b;
    logic        ime_b;
    logic        ack_b;
    logic [7:0]  if_b, ie_b;
    logic        pend_b, req_b;
    logic [15:0] vec_b;
    logic [2:0]  idx_b;

    always #5 clk4_2 = ~clk4_2;

    interrupt_controller u_dut (
        .clk4_2             (clk4_2),
        .reset_n            (reset_n),
        .write              (write),
        .address_bus_offset (addr),
        .data_in            (data_in),
        .int_sig            (int_sig),
        .IME                (ime),
        .int_ack            (int_ack),
        .IF                 (if_o),
        .IE                 (ie_o),
        .int_pending        (pend),
        .int_req            (req),
        .int_vector         (vec),
        .int_index          (idx)
    );

    interrupt_controller #(
        .NUM_INT       (8),
        .VECTOR_STRIDE (16)
    ) u_dut8 (
        .clk4_2             (clk4_2),
        .reset_n            (reset_n),
        .write              (write_b),
        .address_bus_offset (addr_b),
        .data_in            (data_b),
        .int_sig            (sig_b),
        .IME                (ime_b),
        .int_ack            (ack_b),
        .IF                 (if_b),
        .IE                 (ie_b),
        .int_pending        (pend_b),
        .int_req            (req_b),
        .int_vector         (vec_b),
        .int_index          (idx_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: flags, enables and "servicing channel m_idx" as plain data.
    logic [7:0]  m_if, m_ie, m_nf;
    logic [4:0]  m_prev;
    bit          m_busy;
    int          m_idx, m_first;
    logic [15:0] m_vec;

    always @(posedge clk4_2 or negedge reset_n) begin
        if (!reset_n) begin
            m_if   <= '0;
            m_ie   <= '0;
            m_prev <= '0;
            m_busy <= 1'b0;
            m_idx  <= 0;
            m_vec  <= '0;
        end else begin
            m_first = -1;
            for (int i = N - 1; i >= 0; i--)
                if (m_if[i] && m_ie[i]) m_first = i;
            m_nf = m_if;
            if (write && addr == 16'hFF0F) m_nf = {3'b000, data_in[4:0]};
            if (m_busy && int_ack) m_nf[m_idx] = 1'b0;
            for (int i = 0; i < N; i++)
                if (int_sig[i] && !m_prev[i]) m_nf[i] = 1'b1;
            if (m_busy) begin
                if (int_ack || !ime || !m_if[m_idx] || !m_ie[m_idx]) m_busy <= 1'b0;
            end else if (ime && m_first >= 0) begin
                m_busy <= 1'b1;
                m_idx  <= m_first;
                m_vec  <= 16'h0040 + 16'(8 * m_first);
            end
            m_if   <= m_nf;
            m_prev <= int_sig;
            if (write && addr == 16'hFFFF) m_ie <= data_in;
        end
    end

    always @(negedge clk4_2) begin
        if (chk_en) begin
            chk("IF", 32'(if_o), 32'(m_if | 8'hE0));
            chk("IE", 32'(ie_o), 32'(m_ie));
            chk("int_pending", 32'(pend), 32'(|(m_if & m_ie & 8'h1F)));
            chk("int_req", 32'(req), 32'(m_busy));
            if (m_busy) begin
                chk("int_vector", 32'(vec), 32'(m_vec));
                chk("int_index", 32'(idx), 32'(m_idx));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk4_2);
        #1;
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
        write   = 1'b1;
        addr    = a;
        data_in = d;
        cyc(1);
        write   = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; write = 1'b0; addr = '0; data_in = '0; int_sig = '0;
        ime = 1'b0; int_ack = 1'b0;
        write_b = 1'b0; addr_b = '0; data_b = '0; sig_b = '0; ime_b = 1'b0; ack_b = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // reset readback
        chk("rst IF", 32'(if_o), 32'h0E0);
        chk("rst IE", 32'(ie_o), 32'h000);
        chk("rst req", 32'(req), 32'h0);
        chk("rst vec", 32'(vec), 32'h0000);
        chk("rst idx", 32'(idx), 32'h0);
        chk("rst IF8", 32'(if_b), 32'h000);

        // NUM_INT=8, stride 16: channel 7
        write_b = 1'b1; addr_b = 16'hFFFF; data_b = 8'h80;
        cyc(1);
        write_b = 1'b0; ime_b = 1'b1; sig_b[7] = 1'b1;
        cyc(1);
        chk("p8 IF", 32'(if_b), 32'h080);
        chk("p8 pend", 32'(pend_b), 32'h1);
        cyc(1);
        chk("p8 req", 32'(req_b), 32'h1);
        chk("p8 vec", 32'(vec_b), 32'h00B0);
        chk("p8 idx", 32'(idx_b), 32'h7);

        // single timer source
        bus_wr(16'hFFFF, 8'h04);
        ime = 1'b1; int_sig[2] = 1'b1;
        cyc(1);
        chk("tmr IF", 32'(if_o), 32'h0E4);
        chk("tmr req early", 32'(req), 32'h0);
        cyc(1);
        chk("tmr req", 32'(req), 32'h1);
        chk("tmr vec", 32'(vec), 32'h0050);
        chk("tmr idx", 32'(idx), 32'h2);
        cyc(3);
        int_ack = 1'b1;
        cyc(1);
        int_ack = 1'b0;
        chk("tmr ack IF", 32'(if_o), 32'h0E0);
        chk("tmr ack req", 32'(req), 32'h0);
        cyc(5);
        chk("tmr held req", 32'(req), 32'h0);
        chk("tmr held IF", 32'(if_o), 32'h0E0);
        int_sig[2] = 1'b0;

        // priority and freeze
        bus_wr(16'hFFFF, 8'h1F);
        int_sig[4] = 1'b1;
        cyc(2);
        chk("pri req", 32'(req), 32'h1);
        chk("pri vec", 32'(vec), 32'h0060);
        int_sig[0] = 1'b1;
        cyc(2);
        chk("pri frozen vec", 32'(vec), 32'h0060);
        chk("pri frozen idx", 32'(idx), 32'h4);
        chk("pri IF", 32'(if_o), 32'h0F1);
        int_ack = 1'b1;
        cyc(1);
        int_ack = 1'b0;
        chk("pri ack req", 32'(req), 32'h0);
        chk("pri ack IF", 32'(if_o), 32'h0E1);
        cyc(1);
        chk("pri next req", 32'(req), 32'h1);
        chk("pri next vec", 32'(vec), 32'h0040);
        int_ack = 1'b1;
        cyc(1);
        int_ack = 1'b0; int_sig = '0;
        cyc(2);

        // write/edge collision and HALT wake
        ime = 1'b0;
        write = 1'b1; addr = 16'hFF0F; data_in = 8'h00; int_sig[1] = 1'b1;
        cyc(1);
        write = 1'b0;
        chk("coll IF", 32'(if_o), 32'h0E2);
        chk("wake pend", 32'(pend), 32'h1);
        cyc(3);
        chk("wake req", 32'(req), 32'h0);
        int_sig = '0;
        bus_wr(16'hFF0F, 8'h00);
        ime = 1'b1;

        // cancel by bus clear, then ack in IDLE
        int_sig[3] = 1'b1;
        cyc(2);
        chk("cxl req", 32'(req), 32'h1);
        chk("cxl idx", 32'(idx), 32'h3);
        chk("cxl vec", 32'(vec), 32'h0058);
        bus_wr(16'hFF0F, 8'h00);
        chk("cxl req hold", 32'(req), 32'h1);
        chk("cxl IF", 32'(if_o), 32'h0E0);
        cyc(1);
        chk("cxl req drop", 32'(req), 32'h0);
        int_ack = 1'b1;
        cyc(1);
        int_ack = 1'b0;
        chk("idle ack req", 32'(req), 32'h0);
        chk("idle ack IF", 32'(if_o), 32'h0E0);
        int_sig = '0;
        cyc(1);

        // reset mid-REQUEST
        int_sig[0] = 1'b1;
        cyc(2);
        chk("mid req", 32'(req), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid rst req", 32'(req), 32'h0);
        chk("mid rst IF", 32'(if_o), 32'h0E0);
        chk("mid rst IE", 32'(ie_o), 32'h000);
        chk("mid rst vec", 32'(vec), 32'h0000);
        cyc(1);
        reset_n = 1'b1; int_sig = '0;
        cyc(1);

        // randomised traffic
        bus_wr(16'hFFFF, 8'h1F);
        repeat (3000) begin
            write = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 2))
                0: addr = 16'hFF0F;
                1: addr = 16'hFFFF;
                default: addr = 16'hFF40;
            endcase
            data_in = 8'($urandom);
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 7) == 0) int_sig[b] = ~int_sig[b];
            ime     = ($urandom_range(0, 15) != 0);
            int_ack = req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 499) == 0) begin
                reset_n = 1'b0;
                cyc(1);
                reset_n = 1'b1;
            end
            cyc(1);
        end
        write = 1'b0; int_ack = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
